// File: rtl/stop_it_pkg.sv
// Shared types and constants for the Stop It game controller.
package stop_it_pkg;

    localparam int LED_W = 16;
    localparam logic [LED_W-1:0] LEDS_FULL = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WIN,
        LOSE
    } stop_it_state_e;

endpackage

// File: rtl/stop_it_ctrl_tick_gen.sv
// Modulo-N counter with synchronous clear; tick_o marks the last count while enabled.
module tick_gen #(
    parameter int N = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i) begin
            cnt <= '0;
        end else if (en_i) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign tick_o = en_i && (cnt == LAST);

endmodule

// File: rtl/stop_it_ctrl.sv
// Stop It game FSM: drives the LED shifter and judges the stop against the full LED vector.
module stop_it_ctrl
    import stop_it_pkg::*;
#(
    parameter int TICK_CYCLES  = 5_000_000,
    parameter int BLINK_CYCLES = 2_500_000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [LED_W-1:0] leds_i,
    output logic             load_o,
    output logic             shift_o,
    output logic             off_o,
    output logic             win_o,
    output logic             lose_o
);

    stop_it_state_e state;
    logic           grace_on;
    logic           blink_lvl;
    logic           shift_tick;
    logic           grace_done;
    logic           blink_tick;

    // Counters are held at zero outside their owning state, so entering it starts from 0.
    tick_gen #(.N(TICK_CYCLES)) u_shift (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (state != RUN),
        .en_i   (state == RUN),
        .tick_o (shift_tick)
    );

    tick_gen #(.N(TICK_CYCLES)) u_grace (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (!grace_on),
        .en_i   (grace_on),
        .tick_o (grace_done)
    );

    tick_gen #(.N(BLINK_CYCLES)) u_blink (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (state != WIN),
        .en_i   (state == WIN),
        .tick_o (blink_tick)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state     <= IDLE;
            grace_on  <= 1'b0;
            blink_lvl <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    grace_on <= 1'b0;
                    if (start_i) state <= RUN;
                end
                RUN: begin
                    // A stop only wins once the full vector was seen on an earlier cycle.
                    if (stop_i) begin
                        state     <= grace_on ? WIN : LOSE;
                        grace_on  <= 1'b0;
                        blink_lvl <= 1'b1;
                    end else if (grace_done) begin
                        state    <= LOSE;
                        grace_on <= 1'b0;
                    end else if (leds_i == LEDS_FULL) begin
                        grace_on <= 1'b1;
                    end
                end
                WIN: begin
                    if (blink_tick) blink_lvl <= ~blink_lvl;
                    if (start_i)    state     <= IDLE;
                end
                LOSE: begin
                    if (start_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign load_o  = (state == IDLE);
    assign shift_o = shift_tick;
    assign off_o   = (state == WIN) ? blink_lvl : (state == LOSE);
    assign win_o   = (state == WIN);
    assign lose_o  = (state == LOSE);

endmodule

// File: tb/tb_stop_it_ctrl.sv
// Vector table plus hand-written corner sequences for stop_it_ctrl (TICK=4, BLINK=3).
module tb_stop_it_ctrl;

    typedef struct {
        logic        rst_n;
        logic        start;
        logic        stop;
        logic [15:0] leds;
        logic [4:0]  exp;   // {load, shift, off, win, lose}
        logic        chk;
    } vec_t;

    localparam logic [4:0] E_IDLE = 5'b10000;
    localparam logic [4:0] E_RUN  = 5'b00000;
    localparam logic [4:0] E_SHF  = 5'b01000;
    localparam logic [4:0] E_WON  = 5'b00110;
    localparam logic [4:0] E_WOFF = 5'b00010;
    localparam logic [4:0] E_LOSE = 5'b00101;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] leds = 16'h0;
    logic        load, shift, off, win, lose;

    int n_checks = 0;
    int n_fail   = 0;
    logic [4:0] exp_q[$];
    vec_t       vecs[$];

    stop_it_ctrl #(.TICK_CYCLES(4), .BLINK_CYCLES(3)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start),
        .stop_i  (stop),
        .leds_i  (leds),
        .load_o  (load),
        .shift_o (shift),
        .off_o   (off),
        .win_o   (win),
        .lose_o  (lose)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic r, input logic st, input logic sp,
                                input logic [15:0] l, input logic [4:0] e, input logic c);
        vec_t v;
        v.rst_n = r; v.start = st; v.stop = sp; v.leds = l; v.exp = e; v.chk = c;
        vecs.push_back(v);
    endfunction

    // Apply one cycle of inputs; outputs seen in that cycle are checked before the next edge.
    task automatic drive(input logic r, input logic st, input logic sp, input logic [15:0] l,
                         input logic [4:0] e, input logic c, input string name);
        logic [4:0] got, want;
        @(negedge clk);
        rst_n = r; start = st; stop = sp; leds = l;
        if (c) exp_q.push_back(e);
        #1;
        if (c) begin
            want = exp_q.pop_front();
            got  = {load, shift, off, win, lose};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s: got {load,shift,off,win,lose}=%b expected %b at %0t", name, got, want, $time);
            end
            n_checks++;
            if (load && shift) begin
                n_fail++;
                $display("FAIL %s invariant: load=%b shift=%b both high", name, load, shift);
            end
        end
    endtask

    initial begin
        int first;
        logic lvl;

        add(0,0,0,16'h0,E_IDLE,0);
        add(0,0,0,16'h0,E_IDLE,1);
        add(1,0,0,16'h0,E_IDLE,1);
        add(1,0,1,16'h0,E_IDLE,1);          // stop ignored in IDLE
        add(1,1,0,16'h0,E_IDLE,1);          // -> RUN
        for (int p = 0; p < 5; p++) begin   // five shift pulses, start ignored
            add(1,(p==1),0,16'h0,E_RUN,1);
            add(1,0,0,16'h0,E_RUN,1);
            add(1,0,0,16'h0,E_RUN,1);
            add(1,0,0,16'h0,E_SHF,1);
        end
        add(1,0,1,16'h00FF,E_RUN,1);        // early stop -> LOSE
        add(1,0,0,16'h00FF,E_LOSE,1);
        add(1,0,0,16'h0,E_LOSE,1);
        add(1,1,0,16'h0,E_LOSE,1);          // -> IDLE
        add(1,1,1,16'h0,E_IDLE,1);          // start+stop: start acts -> RUN
        add(1,0,0,16'hFFFF,E_RUN,1);        // full seen
        add(1,0,0,16'hFFFF,E_RUN,1);
        add(1,0,1,16'hFFFF,E_RUN,1);        // stop in grace -> WIN
        add(1,0,0,16'hFFFF,E_WON,1);
        add(1,0,1,16'hFFFF,E_WON,1);        // stop ignored in WIN
        add(1,0,0,16'hFFFF,E_WON,1);
        add(1,0,0,16'hFFFF,E_WOFF,1);
        add(1,0,0,16'hFFFF,E_WOFF,1);
        add(1,0,0,16'hFFFF,E_WOFF,1);
        add(1,0,0,16'hFFFF,E_WON,1);
        add(1,1,0,16'hFFFF,E_WON,1);        // -> IDLE
        add(1,1,0,16'h0,E_IDLE,1);          // -> RUN
        add(1,0,0,16'h0,E_RUN,1);
        add(0,0,0,16'h0,E_RUN,1);           // reset mid-RUN
        add(1,0,0,16'h0,E_IDLE,1);
        add(1,1,0,16'h0,E_IDLE,1);          // timeout run
        add(1,0,0,16'hFFFF,E_RUN,1);
        add(1,0,0,16'hFFFF,E_RUN,1);
        add(1,0,0,16'hFFFF,E_RUN,1);
        add(1,0,0,16'hFFFF,E_SHF,1);
        add(1,0,0,16'hFFFF,E_RUN,1);        // grace expires -> LOSE
        add(1,0,0,16'h0,E_LOSE,1);
        add(1,1,0,16'h0,E_LOSE,1);
        add(1,1,0,16'h0,E_IDLE,1);
        add(1,0,1,16'hFFFF,E_RUN,1);        // stop same cycle as first full -> LOSE
        add(1,0,0,16'hFFFF,E_LOSE,1);
        add(1,1,0,16'h0,E_LOSE,1);
        add(1,1,0,16'h0,E_IDLE,1);
        add(1,0,0,16'hFFFF,E_RUN,1);
        add(1,0,0,16'hFFFF,E_RUN,1);
        add(1,0,0,16'hFFFF,E_RUN,1);
        add(1,0,0,16'hFFFF,E_SHF,1);
        add(1,0,1,16'hFFFF,E_RUN,1);        // stop on last grace cycle -> WIN
        add(1,0,0,16'hFFFF,E_WON,1);
        add(0,0,0,16'h0,E_WON,1);           // reset in WIN
        add(1,0,0,16'h0,E_IDLE,1);

        foreach (vecs[i])
            drive(vecs[i].rst_n, vecs[i].start, vecs[i].stop, vecs[i].leds,
                  vecs[i].exp, vecs[i].chk, $sformatf("vec%0d", i));

        // First shift position, bounded search
        drive(1,1,0,16'h0,E_IDLE,1,"seq_start");
        first = -1;
        for (int i = 1; i <= 10 && first < 0; i++) begin
            drive(1,0,0,16'h0,E_RUN,0,"seq_wait");
            if (shift === 1'b1) first = i;
        end
        n_checks++;
        if (first != 4) begin
            n_fail++;
            $display("FAIL first_shift: got RUN cycle %0d expected 4", first);
        end

        // Long blink window
        drive(1,0,0,16'hFFFF,E_RUN,1,"seq_full");
        drive(1,0,1,16'hFFFF,E_RUN,1,"seq_stop");
        for (int k = 0; k < 12; k++) begin
            lvl = ((k / 3) % 2) == 0;
            drive(1,0,0,16'h0,{2'b00,lvl,2'b10},1,$sformatf("blink%0d", k));
        end
        drive(1,1,0,16'h0,{2'b00,1'b1,2'b10},1,"blink_exit");
        drive(1,0,0,16'h0,E_IDLE,1,"seq_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stop_it_ctrl.md
# stop_it_ctrl

Game controller for the Stop It design. It sits directly upstream of the LED shifter and drives that shifter's load, shift and off inputs. It reads back the displayed LED vector to decide whether the player stopped in time. A run begins when start is pressed. The LEDs then fill one position per tick, and the run ends in WIN or LOSE depending on when stop is pressed.

## Interface
- `TICK_CYCLES`, default 5_000_000: clock cycles per shift tick; also the length of the grace window. Legal range is 2 or more.
- `BLINK_CYCLES`, default 2_500_000: clock cycles per half-period of the win blink. Legal range is 2 or more.
- `clk_i` in 1: the single clock.
- `rst_ni` in 1: reset, synchronous and active-low.
- `start_i` in 1: start/restart request. A single-cycle pulse, already debounced.
- `stop_i` in 1: stop request. A single-cycle pulse, already debounced.
- `leds_i` in 16: LED vector fed back from the shifter output.
- `load_o` out 1: to shifter `load_i`.
- `shift_o` out 1: to shifter `shift_i`. A single-cycle pulse.
- `off_o` out 1: to shifter `off_i`.
- `win_o` out 1: high while in WIN.
- `lose_o` out 1: high while in LOSE.

## Operation
- **States:** IDLE, RUN, WIN, LOSE. All outputs are decoded from the state and the counters only.
- **IDLE**
  - Outputs: `load_o`=1, `shift_o`=0, `off_o`=0. The shifter therefore mirrors the switches.
  - `start_i` moves to RUN. `stop_i` is ignored.
- **RUN**
  - Outputs: `load_o`=0, `off_o`=0.
  - The tick counter counts 0..TICK_CYCLES-1 and wraps. `shift_o`=1 exactly when the count equals TICK_CYCLES-1.
  - Full detection: when `leds_i`==16'hFFFF is first observed, a grace counter starts.
    - The grace counter counts 0..TICK_CYCLES-1.
    - Shifting continues during the grace window and is harmless, because the vector stays all ones.
  - `stop_i` while the grace counter is running moves to WIN.
  - `stop_i` before the grace counter has started moves to LOSE. This includes a stop in the same cycle that full is first observed.
  - If the grace counter reaches TICK_CYCLES-1 without `stop_i`, the state moves to LOSE (timeout).
  - `start_i` is ignored.
- **WIN**
  - Outputs: `win_o`=1, `load_o`=0, `shift_o`=0.
  - `off_o` starts at 1 and toggles every BLINK_CYCLES cycles, indefinitely.
  - `start_i` moves to IDLE.
- **LOSE**
  - Outputs: `lose_o`=1, `off_o`=1 steady, `load_o`=0, `shift_o`=0.
  - `start_i` moves to IDLE.
- **Counters:** entering RUN clears the tick and grace counters. Entering WIN clears the blink counter.
- **Invariant:** `load_o` and `shift_o` are never high in the same cycle. The shifter's load-over-shift priority is therefore never exercised.
- **Simultaneous events:** when `start_i` and `stop_i` arrive together, only the input that is meaningful in the current state acts.

## Timing
- **Reset:** with `rst_ni` low at a rising edge, the next state is IDLE and all counters are 0. Resulting outputs: `load_o`=1, `shift_o`=0, `off_o`=0, `win_o`=0, `lose_o`=0.
- **Reset mid-operation:** reset in any state behaves identically.
- **Transitions:** each state transition takes effect at the edge that samples the triggering input. The new outputs are visible in the following cycle.
- **First shift:** the first `shift_o` pulse occurs in the TICK_CYCLES-th cycle of RUN. Subsequent pulses follow every TICK_CYCLES cycles.
- **Feedback latency:** the shifter registers the shift, so `leds_i` reflects a `shift_o` pulse one cycle later. Full detection therefore lags the final shift by one cycle.
- **Blink:** in WIN, `off_o` holds each level for exactly BLINK_CYCLES cycles.

## Structure
- `stop_it_pkg` holds:
  - the state enum typedef `stop_it_state_e` (IDLE, RUN, WIN, LOSE);
  - the constant `LEDS_FULL` = 16'hFFFF;
  - the LED width constant, 16.
- Sub-module `tick_gen`:
  - parameterised modulo-N counter with a synchronous clear and a one-cycle `tick_o` at N-1;
  - instantiated three times: shift tick, grace window, blink.
- The FSM lives in `stop_it_ctrl`.

## Test plan
Parameters for all scenarios: TICK_CYCLES=4, BLINK_CYCLES=3.
1. **Reset:** hold `rst_ni`=0 for 2 cycles → `load_o`=1, all other outputs 0. Asserting reset mid-RUN returns to IDLE after one edge.
2. **Start and shift cadence:** `start_i` pulse → `load_o` drops next cycle. `shift_o` is high for exactly 1 cycle in every 4, first in RUN cycle 4. Check 5 pulses.
3. **Early stop:** in RUN with `leds_i`=16'h00FF, pulse `stop_i` → next cycle `lose_o`=1, `off_o`=1, and no further `shift_o`.
4. **Win:** drive `leds_i`=16'hFFFF, then pulse `stop_i` 2 cycles later.
   - Next cycle: `win_o`=1 and `off_o`=1.
   - Then `off_o` follows the pattern 1,1,1,0,0,0,1,…
5. **Timeout:** hold `leds_i`=16'hFFFF for 4 cycles without `stop_i` → `lose_o`=1 and `off_o`=1.
6. **Restart and ignored start:** `start_i` during RUN causes no state change. `start_i` in WIN or LOSE → IDLE next cycle, with `load_o`=1 and `win_o`=`lose_o`=0.
